hourglass_turn_sequencer: RTL and testbench

// Drives the turn inputs of the 4/7-minute hourglass event model so that a requested interval is measured exactly.
// It is the controller side of that model: it accepts a target time, emits one (turn_small, turn_large) pair per event step,
// and keeps its own sand/elapsed mirror so completion is known without feedback.

---
 rtl/hourglass_pkg.sv | 73 +++++++
 rtl/hourglass_mirror.sv | 75 +++++++
 rtl/hourglass_turn_sequencer.sv | 146 ++++++++++++++
 tb/tb_hourglass_turn_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hourglass_pkg.sv
// Shared types and constants for the 4/7-minute hourglass turn sequencer:
// state encoding, base-script ROM and the request decomposition helpers.
package hourglass_pkg;

    localparam int SMALL_CAP = 4;
    localparam int LARGE_CAP = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_BASE,
        ST_TAIL,
        ST_FIN
    } state_e;

    typedef struct packed {
        logic turn_s;
        logic turn_l;
        logic last;
    } script_entry_t;

    // Four base scripts packed back to back: k=0 @0, k=7 @1, k=9 @3, k=10 @8.
    function automatic script_entry_t base_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    base_rom = 3'b101;
            4'd1:    base_rom = 3'b010;
            4'd2:    base_rom = 3'b001;
            4'd3:    base_rom = 3'b110;
            4'd4:    base_rom = 3'b100;
            4'd5:    base_rom = 3'b010;
            4'd6:    base_rom = 3'b010;
            4'd7:    base_rom = 3'b001;
            4'd8:    base_rom = 3'b110;
            4'd9:    base_rom = 3'b100;
            4'd10:   base_rom = 3'b100;
            4'd11:   base_rom = 3'b001;
            default: base_rom = 3'b001;
        endcase
    endfunction

    function automatic logic [3:0] script_start(input logic [1:0] tmod);
        case (tmod)
            2'd0:    script_start = 4'd0;
            2'd1:    script_start = 4'd3;
            2'd2:    script_start = 4'd8;
            default: script_start = 4'd1;
        endcase
    endfunction

    function automatic logic [3:0] script_k(input logic [1:0] tmod);
        case (tmod)
            2'd0:    script_k = 4'd0;
            2'd1:    script_k = 4'd9;
            2'd2:    script_k = 4'd10;
            default: script_k = 4'd7;
        endcase
    endfunction

    // (T-k)/4 == T/4 - quads, since k mod 4 always equals T mod 4.
    function automatic logic [1:0] script_quads(input logic [1:0] tmod);
        case (tmod)
            2'd0:    script_quads = 2'd0;
            2'd3:    script_quads = 2'd1;
            default: script_quads = 2'd2;
        endcase
    endfunction

    function automatic logic is_unmeasurable(input logic [31:0] t);
        is_unmeasurable = (t == 32'd1) || (t == 32'd2) || (t == 32'd3) ||
                          (t == 32'd5) || (t == 32'd6);
    endfunction

endpackage

// File: rtl/hourglass_mirror.sv
// Local copy of the hourglass sand state: drains to the next event, then
// applies the requested turns, all on a single consume strobe.
module hourglass_mirror #(
    parameter int MSB   = 15,
    parameter int SMALL = 4,
    parameter int LARGE = 7
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           load,
    input  logic [MSB:0]   load_time,
    input  logic           consume,
    input  logic           turn_s,
    input  logic           turn_l,
    output logic [MSB:0]   remaining,
    output logic [2:0]     small_top,
    output logic [2:0]     large_top
);
    localparam int W = MSB + 1;
    localparam logic [2:0] SMALL_Q = 3'(SMALL);
    localparam logic [2:0] LARGE_Q = 3'(LARGE);

    logic [MSB:0] remaining_q, remaining_d;
    logic [2:0]   small_top_q, small_top_d;
    logic [2:0]   large_top_q, large_top_d;
    logic [2:0]   drain, small_left, large_left;

    always_comb begin
        drain = 3'd0;
        if (small_top_q != 3'd0 && large_top_q != 3'd0)
            drain = (small_top_q < large_top_q) ? small_top_q : large_top_q;
        else if (small_top_q != 3'd0)
            drain = small_top_q;
        else
            drain = large_top_q;

        small_left = (small_top_q > drain) ? small_top_q - drain : 3'd0;
        large_left = (large_top_q > drain) ? large_top_q - drain : 3'd0;

        remaining_d = remaining_q;
        small_top_d = small_top_q;
        large_top_d = large_top_q;
        if (load) begin
            remaining_d = load_time;
            small_top_d = 3'd0;
            large_top_d = 3'd0;
        end else if (consume) begin
            remaining_d = remaining_q - W'(drain);
            small_top_d = turn_s ? SMALL_Q - small_left : small_left;
            large_top_d = turn_l ? LARGE_Q - large_left : large_left;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q <= '0;
            small_top_q <= 3'd0;
            large_top_q <= 3'd0;
        end else begin
            remaining_q <= remaining_d;
            small_top_q <= small_top_d;
            large_top_q <= large_top_d;
        end
    end

    assign remaining = remaining_q;
    assign small_top = small_top_q;
    assign large_top = large_top_q;

    a_drain_fits: assert property (@(posedge clock) disable iff (!reset_n)
        consume |-> (W'(drain) <= remaining_q));
    a_tops_capped: assert property (@(posedge clock) disable iff (!reset_n)
        (small_top_q <= SMALL_Q) && (large_top_q <= LARGE_Q));

endmodule

// File: rtl/hourglass_turn_sequencer.sv
// Controller for the 4/7 hourglass model: splits T into a base script plus
// n four-minute tail steps and emits one turn pair per handshaken step.
module hourglass_turn_sequencer
    import hourglass_pkg::*;
#(
    parameter int MSB   = 15,
    parameter int SMALL = SMALL_CAP,
    parameter int LARGE = LARGE_CAP
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [MSB:0] req_time,
    output logic         step_valid,
    input  logic         step_ready,
    output logic         turn_small,
    output logic         turn_large,
    output logic         busy,
    output logic         done,
    output logic         reject,
    output logic [MSB:0] remaining,
    output logic [2:0]   small_top,
    output logic [2:0]   large_top
);
    localparam int W  = MSB + 1;
    localparam int NW = MSB - 1;

    state_e        state_q, state_d;
    logic [MSB:0]  t_q, t_d;
    logic [3:0]    rom_idx_q, rom_idx_d;
    logic [NW-1:0] tail_cnt_q, tail_cnt_d;

    script_entry_t rom_entry;
    logic [1:0]    tmod;
    logic [MSB:0]  k_full;
    logic          check_reject, has_tail, tail_last, mirror_load, consume;

    assign tmod         = t_q[1:0];
    assign k_full       = W'(script_k(tmod));
    assign check_reject = is_unmeasurable(32'(t_q)) || (t_q < k_full);
    assign rom_entry    = base_rom(rom_idx_q);
    assign has_tail     = (tail_cnt_q != '0);
    assign tail_last    = (tail_cnt_q == NW'(1));
    assign consume      = step_valid && step_ready;
    assign busy         = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        rom_idx_d   = rom_idx_q;
        tail_cnt_d  = tail_cnt_q;
        req_ready   = 1'b0;
        step_valid  = 1'b0;
        turn_small  = 1'b0;
        turn_large  = 1'b0;
        done        = 1'b0;
        reject      = 1'b0;
        mirror_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    t_d     = req_time;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (check_reject) begin
                    reject  = 1'b1;
                    state_d = ST_IDLE;
                end else if (t_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    mirror_load = 1'b1;
                    rom_idx_d   = script_start(tmod);
                    tail_cnt_d  = t_q[MSB:2] - NW'(script_quads(tmod));
                    state_d     = ST_BASE;
                end
            end
            ST_BASE: begin
                step_valid = 1'b1;
                // The last base step also restarts the small glass to seed the tail.
                turn_small = rom_entry.turn_s | (rom_entry.last & has_tail);
                turn_large = rom_entry.turn_l;
                if (step_ready) begin
                    if (rom_entry.last)
                        state_d = has_tail ? ST_TAIL : ST_FIN;
                    else
                        rom_idx_d = rom_idx_q + 4'd1;
                end
            end
            ST_TAIL: begin
                step_valid = 1'b1;
                turn_small = !tail_last;
                if (step_ready) begin
                    if (tail_last)
                        state_d = ST_FIN;
                    else
                        tail_cnt_d = tail_cnt_q - NW'(1);
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            rom_idx_q  <= 4'd0;
            tail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            rom_idx_q  <= rom_idx_d;
            tail_cnt_q <= tail_cnt_d;
        end
    end

    hourglass_mirror #(
        .MSB   (MSB),
        .SMALL (SMALL),
        .LARGE (LARGE)
    ) u_mirror (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (mirror_load),
        .load_time (t_q),
        .consume   (consume),
        .turn_s    (turn_small),
        .turn_l    (turn_large),
        .remaining (remaining),
        .small_top (small_top),
        .large_top (large_top)
    );

    a_fin_empty: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == ST_FIN) |-> (remaining == '0));

endmodule

// File: tb/tb_hourglass_turn_sequencer.sv
// Directed plus randomized bench for hourglass_turn_sequencer against a
// queue-based script model and an arithmetic sand model.
module tb_hourglass_turn_sequencer;
    localparam int MSB = 15;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [MSB:0] req_time = '0;
    logic         step_ready = 1'b0;
    logic         req_ready, step_valid, turn_small, turn_large, busy, done, reject;
    logic [MSB:0] remaining;
    logic [2:0]   small_top, large_top;

    int total = 0;
    int bad   = 0;

    typedef logic [1:0] step_t;   // {small, large}
    step_t exp_q[$];
    int m_rem, m_s, m_l;

    hourglass_turn_sequencer #(.MSB(MSB)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_time   (req_time),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .turn_small (turn_small),
        .turn_large (turn_large),
        .busy       (busy),
        .done       (done),
        .reject     (reject),
        .remaining  (remaining),
        .small_top  (small_top),
        .large_top  (large_top)
    );

    always #5 clock = ~clock;

    initial begin
        #20000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int k_of(input int t);
        case (t % 4)
            0:       return 0;
            1:       return 9;
            2:       return 10;
            default: return 7;
        endcase
    endfunction

    // Expected turn list straight from the base-script and tail rules.
    task automatic build_script(input int t);
        int k, n;
        k = k_of(t);
        n = (t - k) / 4;
        exp_q.delete();
        case (k)
            0:  exp_q.push_back(2'b10);
            7:  begin exp_q.push_back(2'b01); exp_q.push_back(2'b00); end
            9:  begin
                    exp_q.push_back(2'b11); exp_q.push_back(2'b10);
                    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
                    exp_q.push_back(2'b00);
                end
            default: begin
                    exp_q.push_back(2'b11); exp_q.push_back(2'b10);
                    exp_q.push_back(2'b10); exp_q.push_back(2'b00);
                end
        endcase
        if (n > 0) exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] | 2'b10;
        for (int i = 0; i < n; i++)
            exp_q.push_back((i < n - 1) ? 2'b10 : 2'b00);
    endtask

    task automatic model_consume(input step_t st);
        int d;
        if (m_s > 0 && m_l > 0) d = (m_s < m_l) ? m_s : m_l;
        else                    d = m_s + m_l;
        m_rem = m_rem - d;
        m_s   = (m_s > d) ? m_s - d : 0;
        m_l   = (m_l > d) ? m_l - d : 0;
        if (st[1]) m_s = 4 - m_s;
        if (st[0]) m_l = 7 - m_l;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_req(input int t, input bit rnd_ready);
        int  k, idx, cycles, limit;
        bit  rej;
        step_t cur;
        k   = k_of(t);
        rej = (t < k) || t == 1 || t == 2 || t == 3 || t == 5 || t == 6;
        $display("request T=%0d rnd_ready=%0d expect_reject=%0d", t, rnd_ready, rej);
        req_valid = 1'b1;
        req_time  = 16'(t);
        chk($sformatf("T%0d req_ready_idle", t), 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk($sformatf("T%0d reject_check", t), 32'(reject), 32'(rej));
        chk($sformatf("T%0d done_check", t), 32'(done), 32'(!rej && t == 0));
        chk($sformatf("T%0d step_valid_check", t), 32'(step_valid), 32'd0);
        chk($sformatf("T%0d busy_check", t), 32'(busy), 32'd1);
        chk($sformatf("T%0d req_ready_busy", t), 32'(req_ready), 32'd0);
        if (!rej && t != 0) begin
            build_script(t);
            m_rem = t; m_s = 0; m_l = 0;
            idx = 0; cycles = 0;
            limit = 4 * exp_q.size() + 100;
            @(negedge clock);
            while (idx < exp_q.size() && cycles < limit) begin
                cycles++;
                cur = exp_q[idx];
                chk($sformatf("T%0d s%0d step_valid", t, idx), 32'(step_valid), 32'd1);
                chk($sformatf("T%0d s%0d turn_small", t, idx), 32'(turn_small), 32'(cur[1]));
                chk($sformatf("T%0d s%0d turn_large", t, idx), 32'(turn_large), 32'(cur[0]));
                chk($sformatf("T%0d s%0d remaining", t, idx), 32'(remaining), 32'(m_rem));
                chk($sformatf("T%0d s%0d small_top", t, idx), 32'(small_top), 32'(m_s));
                chk($sformatf("T%0d s%0d large_top", t, idx), 32'(large_top), 32'(m_l));
                chk($sformatf("T%0d s%0d done_low", t, idx), 32'(done), 32'd0);
                step_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                @(posedge clock);
                if (step_ready) begin
                    model_consume(cur);
                    idx++;
                end
                @(negedge clock);
            end
            step_ready = 1'b0;
            chk($sformatf("T%0d steps_consumed", t), 32'(idx), 32'(exp_q.size()));
            chk($sformatf("T%0d done_fin", t), 32'(done), 32'd1);
            chk($sformatf("T%0d model_rem_zero", t), 32'(m_rem), 32'd0);
            chk($sformatf("T%0d remaining_fin", t), 32'(remaining), 32'd0);
            chk($sformatf("T%0d step_valid_fin", t), 32'(step_valid), 32'd0);
            chk($sformatf("T%0d small_top_fin", t), 32'(small_top), 32'(m_s));
            chk($sformatf("T%0d large_top_fin", t), 32'(large_top), 32'(m_l));
        end
        @(negedge clock);
        chk($sformatf("T%0d done_after", t), 32'(done), 32'd0);
        chk($sformatf("T%0d reject_after", t), 32'(reject), 32'd0);
        chk($sformatf("T%0d busy_after", t), 32'(busy), 32'd0);
        chk($sformatf("T%0d step_valid_after", t), 32'(step_valid), 32'd0);
        chk($sformatf("T%0d req_ready_after", t), 32'(req_ready), 32'd1);
        chk($sformatf("T%0d remaining_after", t), 32'(remaining), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " step_valid"}, 32'(step_valid), 32'd0);
        chk({tag, " turn_small"}, 32'(turn_small), 32'd0);
        chk({tag, " turn_large"}, 32'(turn_large), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " reject"}, 32'(reject), 32'd0);
        chk({tag, " remaining"}, 32'(remaining), 32'd0);
        chk({tag, " small_top"}, 32'(small_top), 32'd0);
        chk({tag, " large_top"}, 32'(large_top), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check_quiet("reset");
        reset_n = 1'b1;
        @(negedge clock);

        run_req(9, 1'b0);
        run_req(10, 1'b0);
        run_req(15, 1'b0);
        run_req(5, 1'b0);
        run_req(1, 1'b0);
        run_req(2, 1'b0);
        run_req(3, 1'b0);
        run_req(6, 1'b0);
        run_req(0, 1'b0);
        run_req(8, 1'b0);
        run_req(7, 1'b0);
        run_req(4, 1'b0);
        run_req(12, 1'b1);
        run_req(12, 1'b1);
        run_req(13, 1'b1);
        run_req(14, 1'b1);

        // Reset in the middle of the base script of T=9.
        $display("request T=9 interrupted by reset");
        req_valid = 1'b1;
        req_time  = 16'd9;
        @(posedge clock);
        @(negedge clock);
        req_valid  = 1'b0;
        step_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("mid_reset busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        @(negedge clock);
        step_ready = 1'b0;
        reset_n    = 1'b1;
        @(negedge clock);
        run_req(4, 1'b0);

        for (int r = 0; r < 25; r++)
            run_req(int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
        run_req(1000, 1'b1);
        run_req(65535, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
